// File: rtl/grant_decoder_pkg.sv
// Shared types and defaults for the grant decoder: FSM state encoding,
// default parameter values and the hold-timer width.
package grant_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam int DEF_SEL_W    = 2;
  localparam int DEF_HOLD_MAX = 15;
  localparam int DEF_CNT_W    = 8;

  // The hold timer is a fixed 8 bits, which is why HOLD_MAX tops out at 255
  localparam int TIMER_W = 8;

  // Timer value seen on the last cycle a grant may be held
  function automatic logic [TIMER_W-1:0] hold_last(input int hold_max);
    return TIMER_W'(hold_max - 1);
  endfunction

endpackage : grant_decoder_pkg

// File: rtl/grant_decoder_decoder_n.sv
// Combinational index-to-one-hot map with enable; the inverse of the
// priority encoder that feeds the grant decoder.
module decoder_n #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]    sel,
  input  logic                en,
  output logic [2**SEL_W-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule : decoder_n

// File: rtl/grant_decoder.sv
// Turns the encoder's winning index into a registered one-hot grant that is
// held until the owner signals done or a hold timeout forces a release.
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int SEL_W    = DEF_SEL_W,
  parameter int HOLD_MAX = DEF_HOLD_MAX,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SEL_W-1:0]    y,
  input  logic                v,
  input  logic                done,
  output logic [2**SEL_W-1:0] g,
  output logic                busy,
  output logic                timeout,
  output logic [CNT_W-1:0]    grant_cnt
);

  localparam int                 N         = 2**SEL_W;
  localparam logic [TIMER_W-1:0] HOLD_LAST = hold_last(HOLD_MAX);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t             state, state_next;
  logic [SEL_W-1:0]   sel_q, sel_next;
  logic [TIMER_W-1:0] timer, timer_next;
  logic               busy_next;
  logic               timeout_next;
  logic [CNT_W-1:0]   cnt_next;
  logic [SEL_W-1:0]   dec_sel;
  logic               dec_en;
  logic [N-1:0]       g_next;

  // While idle the live index is decoded; once granted only the latched index
  // is used, so request changes cannot move an active grant.
  assign dec_sel = (state == ST_IDLE) ? y : sel_q;
  assign dec_en  = (state_next == ST_GRANT);

  decoder_n #(
    .SEL_W (SEL_W)
  ) u_decoder (
    .sel    (dec_sel),
    .en     (dec_en),
    .onehot (g_next)
  );

  // Next-state logic; done takes priority over an expiring timer.
  always_comb begin
    state_next   = state;
    sel_next     = sel_q;
    timer_next   = timer;
    timeout_next = 1'b0;
    cnt_next     = grant_cnt;

    case (state)
      ST_IDLE: begin
        if (v) begin
          state_next = ST_GRANT;
          sel_next   = y;
          timer_next = '0;
        end
      end

      ST_GRANT: begin
        timer_next = timer + 1'b1;
        if (done) begin
          state_next = ST_RELEASE;
          if (grant_cnt != CNT_MAX) begin
            cnt_next = grant_cnt + 1'b1;
          end
        end else if (timer == HOLD_LAST) begin
          state_next   = ST_RELEASE;
          timeout_next = 1'b1;
        end
      end

      ST_RELEASE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  // All outputs are registered alongside the state so they change together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel_q     <= '0;
      timer     <= '0;
      g         <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
      grant_cnt <= '0;
    end else begin
      state     <= state_next;
      sel_q     <= sel_next;
      timer     <= timer_next;
      g         <= g_next;
      busy      <= busy_next;
      timeout   <= timeout_next;
      grant_cnt <= cnt_next;
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(g));
  a_grant_state  : assert property (@(posedge clk) disable iff (rst) ((g != '0) == (state == ST_GRANT)));
  a_timeout_once : assert property (@(posedge clk) disable iff (rst) !(timeout && $past(timeout)));

endmodule : grant_decoder

// File: doc/grant_decoder.md
Name: grant_decoder

Overview:
Consumer end of the priority-encoder interface. Takes the encoded winner index `y` and the valid flag `v` produced by the 4-input priority encoder and turns them into a registered one-hot grant `g[3:0]`. The grant is held until the granted requester signals `done`, or until a hold timeout expires. The block also keeps a saturating count of completed grants, and sits between the encoder and the four requesting units.

Parameters:
- SEL_W, 2, width of the encoded index `y`; the grant width is 2**SEL_W.
- HOLD_MAX, 15, number of GRANT-state cycles allowed before a forced release; legal range is 2..255.
- CNT_W, 8, width of the completed-grant counter.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  asynchronous, active-high reset
- y  in  SEL_W  encoded index of the highest-priority active request
- v  in  1  high when `y` is valid (at least one request is active)
- done  in  1  granted requester has finished; sampled only in GRANT
- g  out  2**SEL_W  registered one-hot grant; all zero when nothing is granted
- busy  out  1  high in GRANT and RELEASE
- timeout  out  1  one-cycle pulse when a grant is force-released
- grant_cnt  out  CNT_W  number of grants completed by `done`, saturating

Behaviour:
- Reset: one clock; `rst` is asynchronous and active-high.
  - When `rst` is asserted, immediately set: state=IDLE, g=0, busy=0, timeout=0, grant_cnt=0, internal timer=0, latched index=0.
  - Reset asserted mid-GRANT drops `g` asynchronously; no timeout pulse is generated.
- State machine: IDLE, GRANT, RELEASE.
- IDLE:
  - On a rising edge with v=1: latch `y`, set g = 1<<y, busy=1, timer=0, go to GRANT.
  - Latency from `v` sampled to `g` valid is one clock.
  - With v=0: stay in IDLE, g=0.
  - `done` is ignored.
- GRANT:
  - `g` holds the latched one-hot value; `y` and `v` are ignored, so changes in the request pattern cannot move the grant.
  - Timer increments each cycle.
  - If done=1: g←0, grant_cnt←grant_cnt+1 (saturating at all ones), go to RELEASE.
  - Else if timer==HOLD_MAX-1: g←0, timeout←1 for exactly one cycle, grant_cnt unchanged, go to RELEASE.
    - The grant therefore lasts at most HOLD_MAX cycles.
  - If `done` and the timeout condition coincide, `done` wins: no timeout pulse, and the counter increments.
- RELEASE:
  - Exactly one cycle with g=0 and busy=1 (turnaround gap).
  - Next state is IDLE unconditionally, with busy=0.
  - A `v` present during RELEASE is not sampled; it is picked up on the first IDLE edge.
  - Back-to-back grants therefore have a minimum period of GRANT cycles + 2.
- Invariants:
  - `g` is either zero or has exactly one bit set.
  - `g` is non-zero only in GRANT.
  - `timeout` is never high for two consecutive cycles.
- Width rules:
  - Timer is 8 bits and compared at equality.
  - grant_cnt does not wrap; at 2**CNT_W-1 it stays there.

Decomposition:
- Shared include file (grant_defs.vh) holds:
  - state encodings ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - default SEL_W, HOLD_MAX, CNT_W values.
- One natural sub-module: `decoder_2to4`, a purely combinational index-to-one-hot map with an enable input, the exact inverse of the priority encoder.
  - The FSM registers its output into `g`.
  - A generic SEL_W version, `decoder_n`, is acceptable.

Test Plan:
1. Reset and idle: assert rst mid-sim with v=1, y=2'b11 → g=0000, busy=0, grant_cnt=0 while rst is high; after release with v=0 for 5 cycles, g stays 0000.
2. Basic decode: with v=1, apply each of y=3,2,1,0 in turn, pulsing done 3 cycles after each grant.
   - g goes to 1000, 0100, 0010, 0001, each one clock after sampling.
   - One RELEASE gap between grants; grant_cnt ends at 4.
3. Grant stability: during GRANT on y=2 (g=0100), change y to 0 and drop v → g stays 0100 until done; a new grant to 0001 appears only after RELEASE+IDLE.
4. Timeout: v=1, y=1, done never asserted with HOLD_MAX=15 → g=0010 for exactly 15 cycles, then g=0000 with timeout high for 1 cycle; grant_cnt unchanged.
5. Coincidence and reset: done asserted on the 15th GRANT cycle → timeout stays 0 and grant_cnt increments. Separately, asserting rst during GRANT → g=0000 immediately, with no timeout pulse.
6. Saturation: with CNT_W=3, complete 10 grants → grant_cnt reads 7 and stays 7.
